// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan controller.
package seg_scan_pkg;

    localparam logic [7:0]  BLANK_CX   = 8'hff;
    localparam int unsigned MAX_DIGITS = 16;

    // Active-low one-hot anode pattern; digit idx sits at bit n_digits-1-idx.
    function automatic logic [MAX_DIGITS-1:0] digit_en_n(input int unsigned idx,
                                                         input int unsigned n_digits);
        return ~(MAX_DIGITS'(1) << (n_digits - 1 - idx));
    endfunction

    function automatic int unsigned on_len_calc(input int unsigned brightness,
                                                input int unsigned scan_div,
                                                input int unsigned duty_bits);
        return (brightness + 1) * (scan_div >> duty_bits);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick_gen.sv
// Modulo-MOD counter advancing on step, with a same-cycle wrap strobe.
module scan_tick_gen #(
    parameter int unsigned MOD = 8,
    parameter int unsigned CW  = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          wrap_c
);

    assign wrap_c = step && (cnt == CW'(MOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= (cnt == CW'(MOD - 1)) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexes N_DIGITS segment bytes onto one cathode bus with blanking,
// blinking, PWM brightness and a frame-complete pulse.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned DUTY_BITS    = 3,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [8*N_DIGITS-1:0] seg_data,
    input  logic [N_DIGITS-1:0]   digit_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic [DUTY_BITS-1:0]  brightness,
    output logic [N_DIGITS-1:0]   led_en,
    output logic [7:0]            led_cx,
    output logic                  frame_tick
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned LW = $clog2(SCAN_DIV + 1);
    localparam int unsigned IW = $clog2(N_DIGITS);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DW-1:0]       div_cnt;
    logic [IW-1:0]       idx;
    logic [FW-1:0]       frame_cnt;
    logic                slot_end;
    logic                frame_end;
    logic                blink_wrap;
    logic [LW-1:0]       on_len;
    logic                blink_phase;
    logic [N_DIGITS-1:0] sel_n;
    logic [N_DIGITS-1:0] sel;
    logic [7:0]          cur_seg;
    logic                lit_c;
    logic                unused_frame_cnt;

    scan_tick_gen #(.MOD(SCAN_DIV), .CW(DW)) u_div (
        .clk    (clk),
        .rst    (rst),
        .step   (1'b1),
        .cnt    (div_cnt),
        .wrap_c (slot_end)
    );

    scan_tick_gen #(.MOD(N_DIGITS), .CW(IW)) u_idx (
        .clk    (clk),
        .rst    (rst),
        .step   (slot_end),
        .cnt    (idx),
        .wrap_c (frame_end)
    );

    // Stepping on frame_end (not the registered tick) flips the phase on the
    // same edge the new frame starts, so digit 0 never straddles two phases.
    scan_tick_gen #(.MOD(BLINK_FRAMES), .CW(FW)) u_frame (
        .clk    (clk),
        .rst    (rst),
        .step   (frame_end),
        .cnt    (frame_cnt),
        .wrap_c (blink_wrap)
    );

    // Only the wrap of the frame counter matters.
    assign unused_frame_cnt = ^frame_cnt;

    assign sel_n = N_DIGITS'(digit_en_n(32'(idx), N_DIGITS));
    assign sel   = ~sel_n;

    always_comb begin
        cur_seg = BLANK_CX;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (idx == IW'(i)) begin
                cur_seg = seg_data[8*(int'(N_DIGITS)-1-i) +: 8];
            end
        end
    end

    assign lit_c = en
                && (LW'(div_cnt) < on_len)
                && !(|(sel & digit_mask))
                && !(blink_phase && (|(sel & blink_mask)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_en      <= '1;
            led_cx      <= BLANK_CX;
            frame_tick  <= 1'b0;
            on_len      <= LW'(SCAN_DIV);
            blink_phase <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (slot_end) begin
                on_len <= LW'(on_len_calc(32'(brightness), SCAN_DIV, DUTY_BITS));
            end
            if (blink_wrap) begin
                blink_phase <= ~blink_phase;
            end
            // A dark digit always gets the blank byte, never a stale one.
            led_en <= lit_c ? sel_n   : '1;
            led_cx <= lit_c ? cur_seg : BLANK_CX;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: per-cycle arithmetic model plus literal pins.
module tb_seg_scan_ctrl;

    localparam int N    = 4;
    localparam int SD   = 8;
    localparam int DB   = 2;
    localparam int BF   = 2;
    localparam int HMAX = 1024;
    localparam logic [31:0] SEG = 32'h11223344;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en;
    logic [31:0] seg_data;
    logic [3:0]  digit_mask;
    logic [3:0]  blink_mask;
    logic [1:0]  brightness;
    logic [3:0]  led_en;
    logic [7:0]  led_cx;
    logic        frame_tick;

    seg_scan_ctrl #(
        .N_DIGITS    (N),
        .SCAN_DIV    (SD),
        .DUTY_BITS   (DB),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .seg_data   (seg_data),
        .digit_mask (digit_mask),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .led_en     (led_en),
        .led_cx     (led_cx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int p        = 0;

    // Input history indexed by scan position since the last reset release.
    logic       h_en [HMAX];
    logic [1:0] h_br [HMAX];
    logic [3:0] h_dm [HMAX];
    logic [3:0] h_bm [HMAX];

    task automatic chk(input string name, input logic [3:0] ee, input logic [7:0] ec,
                       input logic et);
        checks++;
        if (led_en !== ee || led_cx !== ec || frame_tick !== et) begin
            failures++;
            $display("FAIL %s: got en=%b cx=%h tick=%b, need en=%b cx=%h tick=%b",
                     name, led_en, led_cx, frame_tick, ee, ec, et);
        end
    endtask

    // Expected outputs registered from scan position q.
    task automatic model(input int q, output logic [3:0] ee, output logic [7:0] ec,
                         output logic et);
        int s, c, d, f, ph, onl, b;
        logic lit;
        s  = q / SD;
        c  = q % SD;
        d  = s % N;
        f  = s / N;
        ph = (f / BF) % 2;
        b  = N - 1 - d;
        if (s == 0) onl = SD;
        else        onl = (int'(h_br[s*SD-1]) + 1) * (SD / (1 << DB));
        lit = h_en[q] && (c < onl)
           && (((h_dm[q] >> b) & 4'b0001) == 4'b0000)
           && !(ph == 1 && (((h_bm[q] >> b) & 4'b0001) != 4'b0000));
        ee = lit ? ~(4'b0001 << b) : 4'hf;
        ec = lit ? 8'(SEG >> (8*b)) : 8'hff;
        et = (c == SD - 1) && (d == N - 1);
    endtask

    task automatic tick();
        logic [3:0] ee;
        logic [7:0] ec;
        logic       et;
        @(posedge clk);
        if (rst) begin
            p = 0;
        end else begin
            if (p >= HMAX) begin
                $display("FAIL history: position %0d exceeds %0d", p, HMAX);
                $fatal(1, "history overflow");
            end
            h_en[p] = en;
            h_br[p] = brightness;
            h_dm[p] = digit_mask;
            h_bm[p] = blink_mask;
            p++;
        end
        #1;
        if (rst) begin
            chk("reset_hold", 4'hf, 8'hff, 1'b0);
        end else begin
            model(p - 1, ee, ec, et);
            chk($sformatf("model q=%0d", p - 1), ee, ec, et);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_async", 4'hf, 8'hff, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic defaults(input logic [1:0] br);
        en         = 1'b1;
        seg_data   = SEG;
        digit_mask = 4'b0000;
        blink_mask = 4'b0000;
        brightness = br;
    endtask

    initial begin
        defaults(2'd3);
        #2;

        // Full-brightness scan order and frame pulse.
        do_reset();
        run(1);  chk("t1_d0",   4'b0111, 8'h11, 1'b0);
        run(8);  chk("t1_d1",   4'b1011, 8'h22, 1'b0);
        run(23); chk("t1_tick", 4'b1110, 8'h44, 1'b1);
        run(1);  chk("t1_wrap", 4'b0111, 8'h11, 1'b0);
        run(40);

        // Half duty, then a mid-slot brightness change.
        defaults(2'd1);
        do_reset();
        run(18); brightness = 2'd0;
        run(2);  chk("t2_slot2_on",  4'b1101, 8'h33, 1'b0);
        run(1);  chk("t2_slot2_off", 4'b1111, 8'hff, 1'b0);
        run(5);  chk("t2_slot3_on",  4'b1110, 8'h44, 1'b0);
        run(1);  chk("t2_slot3_off", 4'b1111, 8'hff, 1'b0);
        run(20);

        // Permanent blanking of digit 1.
        defaults(2'd3);
        digit_mask = 4'b0100;
        do_reset();
        run(1);  chk("t3_d0",    4'b0111, 8'h11, 1'b0);
        run(8);  chk("t3_blank", 4'b1111, 8'hff, 1'b0);
        run(8);  chk("t3_d2",    4'b1101, 8'h33, 1'b0);
        run(20);

        // Blinking digit 3.
        defaults(2'd3);
        blink_mask = 4'b0001;
        do_reset();
        run(25); chk("t4_f0_lit",  4'b1110, 8'h44, 1'b0);
        run(64); chk("t4_f2_dark", 4'b1111, 8'hff, 1'b0);
        run(64); chk("t4_f4_lit",  4'b1110, 8'h44, 1'b0);
        run(40);

        // Disable mid-slot; scan keeps running underneath.
        defaults(2'd3);
        do_reset();
        run(19); en = 1'b0;
        run(1);  chk("t5_off", 4'b1111, 8'hff, 1'b0);
        run(12); en = 1'b1;
        run(1);  chk("t5_resume", 4'b0111, 8'h11, 1'b0);
        run(10);

        // Asynchronous reset mid-slot while blink phase is dark.
        defaults(2'd3);
        blink_mask = 4'b0001;
        do_reset();
        run(77);
        chk("t6_pre", 4'b1011, 8'h22, 1'b0);
        do_reset();
        run(1);  chk("t6_restart", 4'b0111, 8'h11, 1'b0);
        run(24); chk("t6_visible", 4'b1110, 8'h44, 1'b0);
        run(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
